// File: rtl/sbox_pipe_lanes.sv
// sbox_pipe_lanes: LANES-wide AES S-box (forward or inverse per word) followed
// by STAGES elastic pipeline registers with a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational from out_ready)
//   in_data               LANES bytes, lane i at [8i+7:8i]
//   in_encrypt            1 = SubBytes, 0 = InvSubBytes, applies to the whole word
//   in_tag                opaque sideband returned with the word
//   out_valid / out_ready output handshake
//   out_data, out_encrypt, out_tag   result word and its sideband
//   occupancy             registered count of valid stages
//
// sbox_depth16: one combinational AES S-box core. The substitution is computed
// arithmetically (GF(2^8) inverse plus affine map) instead of from a lookup table.

module sbox_depth16 (
  input  logic [7:0] byte_in,
  input  logic       encrypt,
  output logic [7:0] byte_out
);

  // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
  // Chain: x^2, x^3, x^6, x^12, x^15, x^30, x^60, x^120, x^240, x^254.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  always_comb begin
    byte_out = encrypt ? affine_fwd(gf_inv(byte_in)) : gf_inv(affine_inv(byte_in));
  end

endmodule

module sbox_pipe_lanes #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*LANES-1:0]           in_data,
  input  logic                         in_encrypt,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8*LANES-1:0]           out_data,
  output logic                         out_encrypt,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int DW    = 8 * LANES;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [DW-1:0]    w_sub;
  logic [STAGES:1]  w_adv;
  logic [STAGES:1]  w_up_v;
  logic [STAGES:1]  w_up_enc;
  logic [DW-1:0]    w_up_data [1:STAGES];
  logic [TAG_W-1:0] w_up_tag  [1:STAGES];
  logic [STAGES:1]  w_v_nxt;
  logic [OCC_W-1:0] w_occ_nxt;

  logic [STAGES:1]  r_v;
  logic [STAGES:1]  r_enc;
  logic [DW-1:0]    r_data [1:STAGES];
  logic [TAG_W-1:0] r_tag  [1:STAGES];
  logic [OCC_W-1:0] r_occ;

  // Stage 0: one combinational core per lane
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_depth16 u_core (
      .byte_in  (in_data[8*g +: 8]),
      .encrypt  (in_encrypt),
      .byte_out (w_sub[8*g +: 8])
    );
  end

  // Advance chain from the output back to the input; a scalar carries the
  // running value so the vector never depends on itself.
  always_comb begin : adv_chain
    logic a;
    w_adv         = '0;
    a             = ~r_v[STAGES] | out_ready;
    w_adv[STAGES] = a;
    for (int k = STAGES - 1; k >= 1; k--) begin
      a        = ~r_v[k] | a;
      w_adv[k] = a;
    end
  end

  assign in_ready = w_adv[1];

  always_comb begin
    w_up_v   = '0;
    w_up_enc = '0;
    for (int k = 1; k <= STAGES; k++) begin
      w_up_data[k] = '0;
      w_up_tag[k]  = '0;
    end
    w_up_v[1]    = in_valid & w_adv[1];
    w_up_enc[1]  = in_encrypt;
    w_up_data[1] = w_sub;
    w_up_tag[1]  = in_tag;
    for (int k = 2; k <= STAGES; k++) begin
      w_up_v[k]    = r_v[k-1];
      w_up_enc[k]  = r_enc[k-1];
      w_up_data[k] = r_data[k-1];
      w_up_tag[k]  = r_tag[k-1];
    end
  end

  // Occupancy is registered, so it is computed from the next-state valid bits.
  always_comb begin
    w_v_nxt   = r_v;
    w_occ_nxt = '0;
    for (int k = 1; k <= STAGES; k++) begin
      if (w_adv[k]) w_v_nxt[k] = w_up_v[k];
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[k]);
    end
  end

  // Stages 1..STAGES: payload loads only for a real word, so bubbles clear v only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_enc <= '0;
      r_occ <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
      for (int k = 1; k <= STAGES; k++) begin
        if (w_adv[k] && w_up_v[k]) begin
          r_enc[k]  <= w_up_enc[k];
          r_data[k] <= w_up_data[k];
          r_tag[k]  <= w_up_tag[k];
        end
      end
    end
  end

  assign out_valid   = r_v[STAGES];
  assign out_encrypt = r_enc[STAGES];
  assign out_data    = r_data[STAGES];
  assign out_tag     = r_tag[STAGES];
  assign occupancy   = r_occ;

endmodule
